// File: rtl/shift_sequencer.sv
// shift_sequencer -- multi-cycle accumulator/link shifter.
//
// A START accepted in IDLE or DONE latches AI, LI, OP and CNT. Pass, swap,
// reserved ops and zero-count shifts finish at the START edge itself. The
// rotate and shift ops (010-110) spend CNT cycles in SHIFT, doing one step
// per edge, and then pulse DONE for one cycle.
//
// Ports:
//   CLK    rising-edge clock
//   RST    asynchronous active-high reset
//   START  request, accepted only in IDLE or DONE
//   OP     operation code (000 pass, 001 swap, 010 RAL, 011 RAR,
//          100 SHL, 101 LSR, 110 ASR, 111 pass)
//   CNT    step count
//   AI/LI  accumulator and link operands
//   OE     output enable for AO
//   AO     result register, high-Z when OE=0
//   LO     link register, always driven
//   BUSY   high while in SHIFT
//   DONE   one-cycle result-valid pulse
module shift_sequencer #(
    parameter int WIDTH = 12,
    parameter int CNTW  = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [CNTW-1:0]  CNT,
    input  logic [WIDTH-1:0] AI,
    input  logic             LI,
    input  logic             OE,
    output logic [WIDTH-1:0] AO,
    output logic             LO,
    output logic             BUSY,
    output logic             DONE
);

    localparam int HALF = WIDTH / 2;

    localparam logic [2:0] OP_SWAP = 3'b001;
    localparam logic [2:0] OP_RAL  = 3'b010;
    localparam logic [2:0] OP_RAR  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_LSR  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] res;
    logic             link;
    logic [2:0]       op_q;
    logic [CNTW-1:0]  rem;

    // One step of the latched op, returned as {link, result}.
    function automatic logic [WIDTH:0] step(input logic [2:0] op,
                                            input logic [WIDTH-1:0] r,
                                            input logic l);
        case (op)
            OP_RAL:  step = {r, l};                          // {l,r} rotated left
            OP_RAR:  step = {r[0], l, r[WIDTH-1:1]};         // {l,r} rotated right
            OP_SHL:  step = {r, 1'b0};
            OP_LSR:  step = {r[0], 1'b0, r[WIDTH-1:1]};
            OP_ASR:  step = {r[0], r[WIDTH-1], r[WIDTH-1:1]};
            default: step = {l, r};
        endcase
    endfunction

    logic is_shift_op;
    assign is_shift_op = (OP >= OP_RAL) && (OP <= OP_ASR);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            res   <= '0;
            link  <= 1'b0;
            op_q  <= '0;
            rem   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            case (state)
                S_SHIFT: begin
                    // START and operand inputs are deliberately ignored here.
                    {link, res} <= step(op_q, res, link);
                    rem         <= rem - 1'b1;
                    if (rem == CNTW'(1)) begin
                        state <= S_DONE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept START, so DONE can chain
                    // straight into the next operation.
                    if (START) begin
                        link <= LI;
                        op_q <= OP;
                        rem  <= CNT;
                        if (OP == OP_SWAP)
                            res <= {AI[HALF-1:0], AI[WIDTH-1:HALF]};
                        else
                            res <= AI;
                        if (is_shift_op && (CNT != '0)) begin
                            state <= S_SHIFT;
                            BUSY  <= 1'b1;
                            DONE  <= 1'b0;
                        end else begin
                            state <= S_DONE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end
                    end else begin
                        // Result and link hold until the next accepted START.
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign AO = OE ? res : {WIDTH{1'bz}};
    assign LO = link;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [2:0]  OP = 3'b000;
    logic [4:0]  CNT = 5'd0;
    logic [11:0] AI = 12'h000;
    logic        LI = 1'b0;
    logic        OE = 1'b1;
    wire  [11:0] AO;
    wire         LO;
    wire         BUSY;
    wire         DONE;

    shift_sequencer #(.WIDTH(12), .CNTW(5)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP), .CNT(CNT),
        .AI(AI), .LI(LI), .OE(OE), .AO(AO), .LO(LO),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  cnt;
        logic [11:0] ai;
        logic        li;
        logic [11:0] res;
        logic        lo;
        int          lat;
    } vec_t;

    typedef struct {
        logic [11:0] res;
        logic        lo;
        int          lat;
    } exp_t;

    vec_t vecs[12];
    exp_t sbq[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h want %h", name, act, want);
    endtask

    // Drive one START pulse; the expectation enters the scoreboard as it is driven.
    task automatic start_op(input logic [2:0] op, input logic [4:0] cnt, input logic [11:0] ai,
                            input logic li, input logic [11:0] res, input logic lo,
                            input int lat, input bit push);
        exp_t e;
        @(negedge CLK);
        OP = op; CNT = cnt; AI = ai; LI = li; START = 1'b1;
        if (push) begin
            e.res = res; e.lo = lo; e.lat = lat;
            sbq.push_back(e);
        end
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    // Called #1 after the START edge; counts edges until DONE and BUSY cycles.
    task automatic wait_done(input string tag);
        int   n = 0;
        int   b = 0;
        exp_t e;
        while (DONE !== 1'b1 && n < 80) begin
            if (BUSY === 1'b1) b++;
            @(posedge CLK);
            #1;
            n++;
        end
        if (sbq.size() == 0) begin
            total++;
            $display("FAIL %s: scoreboard empty at DONE", tag);
            return;
        end
        e = sbq.pop_front();
        check({tag, " ao"},      AO, e.res);
        check({tag, " lo"},      LO, e.lo);
        check({tag, " latency"}, n,  e.lat);
        check({tag, " busy"},    b,  e.lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //          op      cnt    ai       li    res      lo    lat
        vecs[0]  = '{3'b010, 5'd1,  12'h800, 1'b0, 12'h000, 1'b1, 1};
        vecs[1]  = '{3'b011, 5'd13, 12'hA5C, 1'b1, 12'hA5C, 1'b1, 13};
        vecs[2]  = '{3'b110, 5'd3,  12'h900, 1'b0, 12'hF20, 1'b0, 3};
        vecs[3]  = '{3'b001, 5'd7,  12'h123, 1'b1, 12'h8C4, 1'b1, 0};
        vecs[4]  = '{3'b000, 5'd5,  12'hABC, 1'b1, 12'hABC, 1'b1, 0};
        vecs[5]  = '{3'b111, 5'd9,  12'h5A5, 1'b0, 12'h5A5, 1'b0, 0};
        vecs[6]  = '{3'b100, 5'd0,  12'h7FF, 1'b0, 12'h7FF, 1'b0, 0};
        vecs[7]  = '{3'b101, 5'd4,  12'h0F8, 1'b1, 12'h00F, 1'b1, 4};
        vecs[8]  = '{3'b100, 5'd20, 12'hFFF, 1'b1, 12'h000, 1'b0, 20};
        vecs[9]  = '{3'b010, 5'd14, 12'h001, 1'b0, 12'h002, 1'b0, 14};
        vecs[10] = '{3'b110, 5'd2,  12'h400, 1'b1, 12'h100, 1'b0, 2};
        vecs[11] = '{3'b011, 5'd1,  12'h001, 1'b0, 12'h000, 1'b1, 1};

        // Reset state
        #3 RST = 1'b1;
        @(posedge CLK); #1;
        check("reset ao",   AO,   12'h000);
        check("reset lo",   LO,   1'b0);
        check("reset busy", BUSY, 1'b0);
        check("reset done", DONE, 1'b0);
        @(negedge CLK) RST = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].op, vecs[i].cnt, vecs[i].ai, vecs[i].li,
                     vecs[i].res, vecs[i].lo, vecs[i].lat, 1'b1);
            wait_done($sformatf("vec%0d", i));
            @(posedge CLK); #1;
            check($sformatf("vec%0d done pulse width", i), DONE, 1'b0);
            check($sformatf("vec%0d idle hold", i), AO, vecs[i].res);
        end

        // Swap, then release AO; a simulator without tristate may read 0 here.
        start_op(3'b001, 5'd0, 12'h123, 1'b1, 12'h8C4, 1'b1, 0, 1'b1);
        wait_done("swap");
        OE = 1'b0;
        #1;
        total++;
        if (AO === 12'hzzz || AO === 12'h000) passed++;
        else $display("FAIL oe release: got %h want zzz", AO);
        check("oe lo", LO, 1'b1);
        OE = 1'b1;

        // Back-to-back: restart straight from the DONE cycle of the swap
        start_op(3'b010, 5'd1, 12'h800, 1'b0, 12'h000, 1'b1, 1, 1'b1);
        wait_done("back2back");

        // SHL CNT=0 completes at once; then STARTs during SHL CNT=5 are ignored
        start_op(3'b100, 5'd0, 12'h7FF, 1'b0, 12'h7FF, 1'b0, 0, 1'b1);
        wait_done("shl cnt0");
        start_op(3'b100, 5'd5, 12'h0C3, 1'b0, 12'h860, 1'b1, 5, 1'b1);
        fork
            begin
                repeat (2) @(negedge CLK);
                START = 1'b1; OP = 3'b011; CNT = 5'd2; AI = 12'hFFF; LI = 1'b1;
                repeat (2) @(negedge CLK);
                START = 1'b0; OP = 3'b000; AI = 12'h000; LI = 1'b0;
            end
        join_none
        wait_done("shl ignore start");
        @(posedge CLK); #1;
        check("shl ignore done pulse width", DONE, 1'b0);

        // Asynchronous reset after 3 steps of RAL CNT=10
        start_op(3'b010, 5'd10, 12'h5A5, 1'b1, 12'h000, 1'b0, 0, 1'b0);
        repeat (3) @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        check("abort busy", BUSY, 1'b0);
        check("abort done", DONE, 1'b0);
        check("abort ao",   AO,   12'h000);
        check("abort lo",   LO,   1'b0);
        @(negedge CLK) RST = 1'b0;
        begin
            int seen = 0;
            for (int k = 0; k < 15; k++) begin
                @(posedge CLK); #1;
                if (DONE === 1'b1) seen++;
            end
            check("abort no done", seen, 0);
        end

        // First START after reset release is taken at the next edge
        RST = 1'b1;
        #1 RST = 1'b0;
        start_op(3'b000, 5'd3, 12'h3C3, 1'b1, 12'h3C3, 1'b1, 0, 1'b1);
        wait_done("post reset");

        check("scoreboard drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named CLK and RST.
REQ-002 The block SHALL expose these parameters: WIDTH, default 12, accumulator width (even, >=4); CNTW, default 5, step-count width.
REQ-003 The block SHALL have these ports:
  CLK    in   1      clock, rising edge
  RST    in   1      asynchronous active-high reset
  START  in   1      request; accepted only in IDLE or DONE
  OP     in   3      operation code
  CNT    in   CNTW   step count
  AI     in   WIDTH  accumulator in
  LI     in   1      link in
  OE     in   1      AO output enable
  AO     out  WIDTH  result; high-Z when OE=0
  LO     out  1      link result, always driven
  BUSY   out  1      shifting in progress
  DONE   out  1      result valid, one-cycle pulse

Function
REQ-004 OP encoding SHALL be: 000 pass; 001 swap halves; 010 RAL (rotate left through link); 011 RAR (rotate right through link); 100 SHL (logical left, zero in); 101 LSR (logical right, zero in); 110 ASR (arithmetic right, MSB replicated); 111 treated as pass.
REQ-005 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-006 On a START accepted at an edge, the block SHALL latch AI, LI, OP and CNT into the result, link, op and remaining-count registers.
REQ-007 At the START edge, pass, reserved ops, or CNT=0 SHALL go to DONE with the result equal to AI and the link equal to LI.
REQ-008 At the START edge, swap SHALL go to DONE with result = {AI[WIDTH/2-1:0], AI[WIDTH-1:WIDTH/2]} and link = LI.
REQ-009 At the START edge, ops 010-110 with CNT>=1 SHALL go to SHIFT.
REQ-010 In SHIFT, each edge SHALL perform exactly one step and decrement the remaining count; when the remaining count reaches 0, the FSM SHALL go to DONE.
REQ-011 RAL and RAR steps SHALL rotate the WIDTH+1 bit {link, result} vector by one position.
REQ-012 SHL, LSR and ASR steps SHALL load the link with the bit shifted out.
REQ-013 Latency SHALL be CNT edges from the START edge to entry into DONE, for ops 010-110 with CNT>=1.
REQ-014 BUSY SHALL be 1 exactly while in SHIFT.
REQ-015 DONE SHALL be 1 exactly while in DONE, which lasts one cycle.
REQ-016 From DONE, the next edge SHALL go to IDLE, or restart if START=1 (back-to-back operation allowed).
REQ-017 START SHALL be ignored while in SHIFT; latched operands and op SHALL be unaffected by input changes during SHIFT.
REQ-018 The result and link registers SHALL hold their values in IDLE until the next accepted START.
REQ-019 CNT > WIDTH+1 SHALL be executed literally, with no modulo reduction.
REQ-020 AO SHALL equal the result register when OE=1 and high-Z when OE=0; OE SHALL not affect internal state.

Reset
REQ-021 While RST=1, regardless of clock, the block SHALL force: state IDLE, result 0, link 0, remaining count 0, BUSY 0, DONE 0.
REQ-022 If RST is asserted mid-SHIFT, the operation SHALL be abandoned with no DONE pulse.
REQ-023 After RST deasserts, the first START SHALL be accepted at the next edge.

Verification (WIDTH=12, CNTW=5)
REQ-024 The bench SHALL apply RAL, CNT=1, AI=0x800, LI=0 -> one edge later DONE=1, AO=0x000, LO=1.
REQ-025 The bench SHALL apply RAR, CNT=13, AI=0xA5C, LI=1 -> BUSY high for 13 cycles, then DONE=1, AO=0xA5C, LO=1.
REQ-026 The bench SHALL apply ASR, CNT=3, AI=0x900, LI=0 -> AO=0xF20, LO=0, DONE 3 edges after START.
REQ-027 The bench SHALL apply swap with AI=0x123, LI=1 -> DONE next cycle, AO=0x8C4, LO=1; then OE=0 -> AO all Z, LO=1.
REQ-028 The bench SHALL apply SHL, CNT=0, AI=0x7FF, followed by START pulses during a later SHL, CNT=5 operation -> the first gives DONE next cycle with AO=0x7FF; the mid-operation STARTs are ignored and the result is computed from the original operands.
REQ-029 The bench SHALL apply RAL, CNT=10, with RST asserted asynchronously after 3 steps -> BUSY=0, DONE=0, AO=0x000 (OE=1), LO=0 immediately, and no DONE pulse afterward.
